// File: rtl/picobus_arbiter.sv
// ----------------------------------------------------------------------------
// picobus_arbiter
//   Shares the housekeeping port bus between two requesters: requester 0 (the
//   UART command bridge) and requester 1 (an autonomous agent such as a
//   register initialiser or status poller). Each granted request becomes one
//   well-formed bus cycle: IDLE (arbitrate/latch) -> SETUP (port_id settles)
//   -> STROBE (single strobe + ack). Read data is captured from in_port at the
//   end of SETUP, so it is valid in the ack cycle and held afterwards.
//
// Ports
//   clk, reset            system clock, synchronous active-high reset
//   reqN/weN/addrN/wdataN requester N request, direction (1=write), port, data
//   ackN                  one-cycle completion pulse to requester N
//   rdataN                requester N read data (valid at ackN, then held)
//   port_id/out_port      bus port select / write data (held between cycles)
//   write_strobe          one-cycle bus write pulse
//   read_strobe           one-cycle bus read pulse
//   in_port               bus read data, combinational function of port_id
//   busy                  high whenever the FSM is not in IDLE
// ----------------------------------------------------------------------------
module picobus_arbiter #(
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic       we0,
    input  logic [7:0] addr0,
    input  logic [7:0] wdata0,
    output logic       ack0,
    output logic [7:0] rdata0,
    input  logic       req1,
    input  logic       we1,
    input  logic [7:0] addr1,
    input  logic [7:0] wdata1,
    output logic       ack1,
    output logic [7:0] rdata1,
    output logic [7:0] port_id,
    output logic [7:0] out_port,
    output logic       write_strobe,
    input  logic [7:0] in_port,
    output logic       read_strobe,
    output logic       busy
);

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                grant_q, grant_d;
    logic                we_q, we_d;
    logic                last_grant_q, last_grant_d;
    logic [ADDR_W-1:0]   port_id_d;
    logic [DATA_W-1:0]   out_port_d;
    logic                write_strobe_d, read_strobe_d;
    logic                ack0_d, ack1_d;
    logic [DATA_W-1:0]   rdata0_d, rdata1_d;
    logic                busy_d;
    logic                winner_c;

    // Arbitration winner; only meaningful when at least one request is up.
    always_comb begin
        winner_c = 1'b0;
        if (req0 && req1) begin
            winner_c = ROUND_ROBIN ? ~last_grant_q : 1'b0;
        end else begin
            winner_c = req1;
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d        = state_q;
        grant_d        = grant_q;
        we_d           = we_q;
        last_grant_d   = last_grant_q;
        port_id_d      = port_id;
        out_port_d     = out_port;
        rdata0_d       = rdata0;
        rdata1_d       = rdata1;
        write_strobe_d = 1'b0;
        read_strobe_d  = 1'b0;
        ack0_d         = 1'b0;
        ack1_d         = 1'b0;

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    grant_d    = winner_c;
                    port_id_d  = winner_c ? addr1  : addr0;
                    out_port_d = winner_c ? wdata1 : wdata0;
                    we_d       = winner_c ? we1    : we0;
                    state_d    = SETUP;
                end
            end
            SETUP: begin
                // in_port has had a full cycle to settle on the stable port_id.
                write_strobe_d = we_q;
                read_strobe_d  = ~we_q;
                if (grant_q) begin
                    ack1_d = 1'b1;
                    if (!we_q) begin
                        rdata1_d = in_port;
                    end
                end else begin
                    ack0_d = 1'b1;
                    if (!we_q) begin
                        rdata0_d = in_port;
                    end
                end
                state_d = STROBE;
            end
            STROBE: begin
                last_grant_d = grant_q;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            we_q         <= 1'b0;
            last_grant_q <= 1'b1;
            port_id      <= '0;
            out_port     <= '0;
            write_strobe <= 1'b0;
            read_strobe  <= 1'b0;
            ack0         <= 1'b0;
            ack1         <= 1'b0;
            rdata0       <= '0;
            rdata1       <= '0;
            busy         <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            we_q         <= we_d;
            last_grant_q <= last_grant_d;
            port_id      <= port_id_d;
            out_port     <= out_port_d;
            write_strobe <= write_strobe_d;
            read_strobe  <= read_strobe_d;
            ack0         <= ack0_d;
            ack1         <= ack1_d;
            rdata0       <= rdata0_d;
            rdata1       <= rdata1_d;
            busy         <= busy_d;
        end
    end

endmodule
